// File: rtl/opi_phy_pkg.sv
// Shared definitions for the OPI PHY gearboxes: collector states, word lengths
// and the byte-lane mapping helper.
package opi_phy_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam logic [2:0] BYTES_32B = 3'd4;
  localparam logic [2:0] BYTES_16B = 3'd2;

  // Byte k of a word of 'need' bytes lands in lane need-1-k when MSB-first, else lane k.
  function automatic logic [1:0] lane_idx(input logic [1:0] k, input logic [2:0] need,
                                          input logic msb_first);
    logic [2:0] rev;
    rev = need - 3'd1 - {1'b0, k};
    return msb_first ? rev[1:0] : k;
  endfunction

endpackage

// File: rtl/gear_8b_32b.sv
// Receive gearbox: assembles captured bytes into 16- or 32-bit words and
// presents each finished word with a single-cycle valid pulse.
module gear_8b_32b
  import opi_phy_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clkin,
  input  logic        reset,
  input  logic        din_valid,
  input  logic [7:0]  din,
  input  logic        sof,
  input  logic        lo16b,
  input  logic        err_clr,
  output logic [31:0] dout,
  output logic        dout_valid,
  output logic        err
);

  state_t      state_r, state_nxt_s;
  logic [1:0]  cnt_r;
  logic [2:0]  need_r;
  logic [31:0] asm_r;
  logic [31:0] dout_r;
  logic        dout_valid_r;
  logic        err_r;

  logic        start_s, store_s, done_s, err_set_s;
  logic [2:0]  need_sof_s;
  logic [2:0]  cnt_inc_s;
  logic [1:0]  lane_s;

  assign need_sof_s = lo16b ? BYTES_16B : BYTES_32B;
  assign cnt_inc_s  = {1'b0, cnt_r} + 3'd1;
  // A starting byte is always byte 0 of the freshly latched length.
  assign lane_s     = start_s ? lane_idx(2'd0, need_sof_s, MSB_FIRST)
                              : lane_idx(cnt_r, need_r, MSB_FIRST);

  // Next-state and byte-action decode.
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    store_s     = 1'b0;
    done_s      = 1'b0;
    err_set_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (din_valid && sof) begin
          start_s     = 1'b1;
          state_nxt_s = COLLECT;
        end else if (din_valid) begin
          err_set_s   = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      COLLECT: begin
        if (din_valid && sof) begin
          err_set_s   = 1'b1;
          start_s     = 1'b1;
        end else if (din_valid) begin
          store_s = 1'b1;
          if (cnt_inc_s == need_r) begin
            done_s      = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = COLLECT;
          end
        end else begin
          state_nxt_s = COLLECT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, assembly register, output word and sticky error.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      cnt_r        <= 2'd0;
      need_r       <= 3'd0;
      asm_r        <= 32'd0;
      dout_r       <= 32'd0;
      dout_valid_r <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      dout_valid_r <= done_s;
      if (err_set_s) begin
        err_r <= 1'b1;
      end else if (err_clr) begin
        err_r <= 1'b0;
      end
      if (start_s) begin
        // Clearing first keeps the unused upper half zero for 2-byte words.
        asm_r                       <= 32'd0;
        asm_r[{lane_s, 3'b000} +: 8] <= din;
        cnt_r                       <= 2'd1;
        need_r                      <= need_sof_s;
      end else if (store_s) begin
        asm_r[{lane_s, 3'b000} +: 8] <= din;
        if (done_s) begin
          dout_r                       <= asm_r;
          dout_r[{lane_s, 3'b000} +: 8] <= din;
          cnt_r                        <= 2'd0;
        end else begin
          cnt_r <= cnt_r + 2'd1;
        end
      end
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign err        = err_r;

endmodule

// File: tb/tb_gear_8b_32b.sv
// Scoreboard bench for gear_8b_32b: an MSB-first and an LSB-first instance share
// one randomized byte stream checked against a word-level reference model.
module tb_gear_8b_32b;

  logic        clkin = 1'b0;
  logic        reset = 1'b1;
  logic        din_valid = 1'b0, sof = 1'b0, lo16b = 1'b0, err_clr = 1'b0;
  logic [7:0]  din = 8'd0;
  logic [31:0] dout_m, dout_l;
  logic        dv_m, dv_l, err_m, err_l;

  int errors = 0;
  int checks = 0;

  logic [31:0] q_m[$];
  logic [31:0] q_l[$];
  logic [31:0] last_m = 32'd0, last_l = 32'd0;

  // reference model: bytes of the word in progress, in arrival order
  logic [7:0]  word[$];
  int          need = 0;
  bit          active = 1'b0;
  bit          err_exp = 1'b0;
  bit          done_p = 1'b0;
  logic [31:0] exp_m_p, exp_l_p;

  always #5 clkin = ~clkin;

  gear_8b_32b #(.MSB_FIRST(1'b1)) dut_m (
    .clkin(clkin), .reset(reset), .din_valid(din_valid), .din(din), .sof(sof),
    .lo16b(lo16b), .err_clr(err_clr), .dout(dout_m), .dout_valid(dv_m), .err(err_m));

  gear_8b_32b #(.MSB_FIRST(1'b0)) dut_l (
    .clkin(clkin), .reset(reset), .din_valid(din_valid), .din(din), .sof(sof),
    .lo16b(lo16b), .err_clr(err_clr), .dout(dout_l), .dout_valid(dv_l), .err(err_l));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_byte(input bit v, input logic [7:0] b, input bit s, input bit l,
                            input bit c);
    bit set;
    set    = 1'b0;
    done_p = 1'b0;
    if (v) begin
      if (s) begin
        if (active) set = 1'b1;
        word.delete();
        word.push_back(b);
        need   = l ? 2 : 4;
        active = 1'b1;
      end else if (!active) begin
        set = 1'b1;
      end else begin
        word.push_back(b);
        if (word.size() == need) begin
          exp_m_p = 32'd0;
          exp_l_p = 32'd0;
          for (int k = 0; k < need; k++) begin
            exp_m_p = exp_m_p | ({24'd0, word[k]} << (8 * (need - 1 - k)));
            exp_l_p = exp_l_p | ({24'd0, word[k]} << (8 * k));
          end
          done_p = 1'b1;
          active = 1'b0;
        end
      end
    end
    if (set) err_exp = 1'b1;
    else if (c) err_exp = 1'b0;
  endtask

  // one clock cycle of stimulus; called just after a rising edge
  task automatic cyc(input bit v, input logic [7:0] b, input bit s, input bit l, input bit c);
    din_valid = v; din = b; sof = s; lo16b = l; err_clr = c;
    model_byte(v, b, s, l, c);
    @(posedge clkin);
    #1;
    if (done_p) begin
      q_m.push_back(exp_m_p);
      q_l.push_back(exp_l_p);
    end
    check("err_m", 32'(err_m), 32'(err_exp));
    check("err_l", 32'(err_l), 32'(err_exp));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clkin);
    #1;
    reset = 1'b1;
    din_valid = 1'b0; sof = 1'b0; lo16b = 1'b0; err_clr = 1'b0;
    check("pending_m", 32'(q_m.size()), 32'd0);
    check("pending_l", 32'(q_l.size()), 32'd0);
    q_m.delete(); q_l.delete();
    word.delete();
    active = 1'b0; err_exp = 1'b0; done_p = 1'b0;
    last_m = 32'd0; last_l = 32'd0;
    #1;
    check("rst_dout_m", dout_m, 32'd0);
    check("rst_dout_l", dout_l, 32'd0);
    check("rst_valid", {30'd0, dv_m, dv_l}, 32'd0);
    check("rst_err", {30'd0, err_m, err_l}, 32'd0);
    repeat (2) @(negedge clkin);
    #1;
    reset = 1'b0;
  endtask

  // monitor: a pulse is required exactly when a completed word is queued
  always @(negedge clkin) begin
    if (!reset) begin
      check("valid_m", 32'(dv_m), 32'(q_m.size() > 0));
      if (q_m.size() > 0) last_m = q_m.pop_front();
      check("dout_m", dout_m, last_m);
      check("valid_l", 32'(dv_l), 32'(q_l.size() > 0));
      if (q_l.size() > 0) last_l = q_l.pop_front();
      check("dout_l", dout_l, last_l);
    end
  end

  initial begin
    do_reset();
    // 4-byte word, consecutive bytes
    cyc(1, 8'hAA, 1, 0, 0); cyc(1, 8'hBB, 0, 0, 0); cyc(1, 8'hCC, 0, 0, 0); cyc(1, 8'hDD, 0, 0, 0);
    idle(2);
    // 2-byte word, then a gapped 4-byte word
    cyc(1, 8'h55, 1, 1, 0); cyc(1, 8'h66, 0, 0, 0); idle(1);
    cyc(1, 8'h11, 1, 0, 0); idle(1); cyc(1, 8'h22, 0, 1, 0); idle(1);
    cyc(1, 8'h33, 0, 0, 0); idle(1); cyc(1, 8'h44, 0, 0, 0); idle(2);
    // back-to-back words
    cyc(1, 8'hAA, 1, 0, 0); cyc(1, 8'hBB, 0, 0, 0); cyc(1, 8'hCC, 0, 0, 0); cyc(1, 8'hDD, 0, 0, 0);
    cyc(1, 8'h11, 1, 0, 0); cyc(1, 8'h22, 0, 0, 0); cyc(1, 8'h33, 0, 0, 0); cyc(1, 8'h44, 0, 0, 0);
    // back-to-back 2-byte words
    cyc(1, 8'h12, 1, 1, 0); cyc(1, 8'h34, 0, 0, 0); cyc(1, 8'h56, 1, 1, 0); cyc(1, 8'h78, 0, 0, 0);
    idle(2);
    // framing errors, clear, restart mid-word, set beats clear
    cyc(1, 8'h77, 0, 0, 0); idle(1); cyc(0, 8'h00, 0, 0, 1);
    cyc(1, 8'hAA, 1, 0, 0); cyc(1, 8'hBB, 0, 0, 0);
    cyc(1, 8'h11, 1, 0, 0); cyc(1, 8'h22, 0, 0, 0); cyc(1, 8'h33, 0, 0, 0); cyc(1, 8'h44, 0, 0, 0);
    idle(1); cyc(0, 8'h00, 0, 0, 1); cyc(1, 8'h99, 0, 0, 1); cyc(0, 8'h00, 0, 0, 1);
    // reverse byte order stream
    cyc(1, 8'hDD, 1, 0, 0); cyc(1, 8'hCC, 0, 0, 0); cyc(1, 8'hBB, 0, 0, 0); cyc(1, 8'hAA, 0, 0, 0);
    idle(2);
    // reset mid-word, then a 2-byte word
    cyc(1, 8'hAA, 1, 0, 0); cyc(1, 8'hBB, 0, 0, 0);
    do_reset();
    cyc(1, 8'hCC, 1, 1, 0); cyc(1, 8'hDD, 0, 0, 0); idle(2);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      cyc($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 4) == 0,
          $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
    end
    idle(3);
    check("final_pending_m", 32'(q_m.size()), 32'd0);
    check("final_pending_l", 32'(q_l.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gear_8b_32b.md
# gear_8b_32b

Byte-to-word deserializer for the OPI PHY read path, the receive-direction counterpart of the 32b→8b transmit gearbox. Collects bytes captured from the octal bus, one per qualified `clkin` cycle, and assembles them into 32-bit words, or 16-bit words in the low half. Emits each completed word with a one-cycle valid pulse to the controller. Sits between the PHY capture flops and the controller read datapath.

## Interface
- `MSB_FIRST`, 1, 1: first byte of a word lands in the most significant lane; 0: first byte lands in the least significant lane
- `clkin`  in  1  single clock; all logic on posedge
- `reset`  in  1  asynchronous, active-high reset
- `din_valid`  in  1  `din` carries a byte this cycle
- `din`  in  8  captured byte
- `sof`  in  1  start of word; qualified by `din_valid`; marks the first byte of a word
- `lo16b`  in  1  sampled only with `sof & din_valid`; 1 = 2-byte word, 0 = 4-byte word
- `err_clr`  in  1  clears `err`
- `dout`  out  32  last completed word; held until the next completion
- `dout_valid`  out  1  one-cycle pulse per completed word
- `err`  out  1  sticky framing error

## Operation
- State machine: IDLE, COLLECT. Byte counter `cnt` is 2 bits. Latched length `need` is 2 if `lo16b` else 4.
- **IDLE:**
  - `din_valid & sof`: write the byte to lane 0, latch `need`, set `cnt`=1, go to COLLECT.
  - `din_valid & !sof`: drop the byte, set `err`, stay in IDLE.
- **COLLECT:**
  - `din_valid & !sof`: write the byte to lane `cnt`, increment `cnt`.
  - If `cnt+1 == need`: load `dout` from the assembly register plus this byte, pulse `dout_valid`, return to IDLE.
  - `din_valid & sof`: discard the partial word, set `err`, restart as in IDLE using this byte as lane 0, re-latching `lo16b`.
  - `din_valid`=0: hold state. Gaps of any length are allowed; there is no timeout.
- **Lane mapping, 4-byte word:**
  - `MSB_FIRST`=1: byte k goes to `dout[31-8k -: 8]`.
  - `MSB_FIRST`=0: byte k goes to `dout[8k +: 8]`.
- **Lane mapping, 2-byte word:** bytes occupy `dout[15:0]` with the same ordering rule inside the half; `dout[31:16]` = 0.
- Assembly register is separate from `dout`. `dout` changes only on completion; it never shows partial words.
- Same-cycle `err` set and `err_clr`: set wins.
- `lo16b` is ignored on non-`sof` bytes.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `err`=0, state IDLE, `cnt`=0, assembly register 0.
- `reset` asserted mid-word: the partial word is lost and no `dout_valid` is produced.
- Latency: `dout`/`dout_valid` update on the edge that samples the last byte, so they are visible the cycle after the last byte is presented.
- Throughput: back-to-back words with no idle cycle are allowed. `sof` on the cycle immediately after the last byte starts the next word while `dout_valid` is high for the previous one.
- Minimum word spacing: 2 cycles for 16-bit words, 4 cycles for 32-bit words.
- `dout_valid` is never high for two consecutive cycles unless two words complete on consecutive cycles. That cannot happen for 2-byte words, so `dout_valid` is always a single-cycle pulse.

## Structure
- Shared package `opi_phy_pkg`:
  - state enum (IDLE, COLLECT)
  - constants `BYTES_32B`=4 and `BYTES_16B`=2
- Single module, no sub-modules. Lane-write logic is an indexed byte write inside one always_ff block.

## Test plan
- `MSB_FIRST`=1, bytes AA(sof),BB,CC,DD on consecutive cycles → one cycle later `dout`=32'hAABBCCDD, `dout_valid` pulses once, `err`=0.
- `MSB_FIRST`=1, 55(sof,lo16b),66 → `dout`=32'h00005566 one cycle after byte 66. Then 11(sof),22,33,44 with one idle cycle between each byte → `dout`=32'h11223344, exactly one pulse.
- Back-to-back: AA(sof),BB,CC,DD,11(sof),22,33,44 with no gaps → two pulses 4 cycles apart with values AABBCCDD then 11223344.
- Framing errors:
  - 77 without sof while in IDLE → no pulse, `err`=1.
  - Then `err_clr` → `err`=0.
  - Then AA(sof),BB,11(sof),22,33,44 → `err`=1 and a single pulse with 11223344.
- `MSB_FIRST`=0: DD(sof),CC,BB,AA → `dout`=32'hAABBCCDD.
- Assert `reset` after AA(sof),BB → `dout`=0, no pulse. After release, CC(sof),DD(lo16b on CC) → `dout`=32'h0000CCDD.
